mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin CPU/host arbiter driving one single-port synchronous RAM through IDLE/ACCESS/WAIT/DONE.
// Define ARB_WRPROT_EN to block CPU writes into the program area (top two address bits 00).
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cpu_state,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_host,
  output logic              wp_fault
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_WAIT   = 2'b10,
    S_DONE   = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic                grant_host_q, grant_host_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                host_ack_q, host_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
  logic                busy_q, busy_d;
  logic                wp_fault_q, wp_fault_d;

  logic                cpu_elig;
  logic                pick_host;
  logic                sel_we;
  logic                sel_prot;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Arbitration: on a tie the requester that did not win last time is chosen.
  always_comb begin
    cpu_elig  = cpu_req & (cpu_state == 2'b11);
    pick_host = host_req & (~cpu_elig | ~grant_host_q);
    sel_we    = pick_host ? host_we    : cpu_we;
    sel_addr  = pick_host ? host_addr  : cpu_addr;
    sel_wdata = pick_host ? host_wdata : cpu_wdata;
`ifdef ARB_WRPROT_EN
    sel_prot  = ~pick_host & cpu_we & (cpu_addr[ADDR_W-1 -: 2] == 2'b00);
`else
    sel_prot  = 1'b0;
`endif
  end

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d      = state_q;
    grant_host_d = grant_host_q;
    we_d         = we_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    wp_fault_d   = wp_fault_q;
    busy_d       = busy_q;
    mem_addr_d   = {ADDR_W{1'b0}};
    mem_wdata_d  = {DATA_W{1'b0}};
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    cpu_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_elig | host_req) begin
          state_d      = S_ACCESS;
          busy_d       = 1'b1;
          grant_host_d = pick_host;
          we_d         = sel_we;
          // The strobe registers double as the latched request for the ACCESS cycle.
          mem_addr_d   = sel_addr;
          mem_wdata_d  = sel_wdata;
          mem_read_d   = ~sel_we;
          mem_write_d  = sel_we & ~sel_prot;
          wp_fault_d   = wp_fault_q | sel_prot;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_ACCESS: begin
        state_d = S_WAIT;
        busy_d  = 1'b1;
      end
      S_WAIT: begin
        state_d    = S_DONE;
        busy_d     = 1'b1;
        cpu_ack_d  = ~grant_host_q;
        host_ack_d = grant_host_q;
        if (!we_q && grant_host_q) begin
          host_rdata_d = mem_rdata;
        end else if (!we_q) begin
          cpu_rdata_d = mem_rdata;
        end else begin
          host_rdata_d = host_rdata_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      grant_host_q <= 1'b1;
      we_q         <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      cpu_rdata_q  <= {DATA_W{1'b0}};
      host_rdata_q <= {DATA_W{1'b0}};
      busy_q       <= 1'b0;
      wp_fault_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_host_q <= grant_host_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      cpu_ack_q    <= cpu_ack_d;
      host_ack_q   <= host_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
      busy_q       <= busy_d;
      wp_fault_q   <= wp_fault_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign cpu_ack    = cpu_ack_q;
  assign host_ack   = host_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign host_rdata = host_rdata_q;
  assign busy       = busy_q;
  assign grant_host = grant_host_q;
  assign wp_fault   = wp_fault_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of memory contents and grant order.
module tb_mem_port_arbiter;
  logic       clk, reset;
  logic [1:0] cpu_state;
  logic       cpu_req, cpu_we, host_req, host_we;
  logic [7:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic       cpu_ack, host_ack, mem_read, mem_write, busy, grant_host, wp_fault;
  logic [7:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;

  int checks, failures;
  logic [7:0] ram [256];
  logic [7:0] model_mem [256];
  logic [7:0] ram_q;
  logic       ram_clear;
  bit         last_host;
  logic [7:0] m_cpu_rdata, m_host_rdata;
  bit         m_wp;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .cpu_state(cpu_state),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy), .grant_host(grant_host), .wp_fault(wp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data valid the cycle after mem_read.
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 37 + 11);
    end else begin
      if (mem_read) ram_q <= ram[mem_addr];
      if (mem_write) ram[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = ram_q;

  function automatic bit is_prot(input bit host, input bit we, input logic [7:0] a);
`ifdef ARB_WRPROT_EN
    return !host && we && (a < 8'h40);
`else
    return 1'b0;
`endif
  endfunction

  task automatic reset_model();
    last_host = 1'b1;
    m_cpu_rdata = 8'h00;
    m_host_rdata = 8'h00;
    m_wp = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; cpu_req = 1'b0; host_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    reset_model();
  endtask

  // One request window: drive at negedge, predict outcome, follow the access to completion.
  task automatic run_txn(input logic [1:0] cs, input bit cr, input bit cw, input logic [7:0] ca,
                         input logic [7:0] cd, input bit hr, input bit hw, input logic [7:0] ha,
                         input logic [7:0] hd);
    bit ph, ewe, prot;
    logic [7:0] ea, ed;
    @(negedge clk);
    cpu_state = cs; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    if (!(cr && cs == 2'b11) && !hr) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || cpu_ack !== 1'b0 || host_ack !== 1'b0) begin
        failures++;
        $display("FAIL idle_no_grant: busy=%b rd=%b wr=%b cack=%b hack=%b required all 0", busy, mem_read, mem_write, cpu_ack, host_ack);
      end
      cpu_req = 1'b0; host_req = 1'b0;
      return;
    end
    ph = hr && !((cr && cs == 2'b11) && last_host);
    last_host = ph;
    ewe = ph ? hw : cw;
    ea = ph ? ha : ca;
    ed = ph ? hd : cd;
    prot = is_prot(ph, ewe, ea);
    @(posedge clk); #1;
    checks++;
    if (mem_read !== !ewe || mem_write !== (ewe && !prot) || mem_addr !== ea || mem_wdata !== ed || grant_host !== ph || busy !== 1'b1) begin
      failures++;
      $display("FAIL access_cycle: rd=%b wr=%b addr=%h wdata=%h gh=%b busy=%b required rd=%b wr=%b addr=%h wdata=%h gh=%b busy=1",
               mem_read, mem_write, mem_addr, mem_wdata, grant_host, busy, !ewe, ewe && !prot, ea, ed, ph);
    end
    // Scramble request fields and cpu_state: the access in flight must not notice.
    cpu_state = 2'($urandom_range(0, 3));
    cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 8'($urandom_range(0, 255)); cpu_wdata = 8'($urandom_range(0, 255));
    host_we = 1'($urandom_range(0, 1)); host_addr = 8'($urandom_range(0, 255)); host_wdata = 8'($urandom_range(0, 255));
    @(posedge clk); #1;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00 || cpu_ack !== 1'b0 || host_ack !== 1'b0) begin
      failures++;
      $display("FAIL wait_cycle: rd=%b wr=%b addr=%h wdata=%h cack=%b hack=%b required all 0", mem_read, mem_write, mem_addr, mem_wdata, cpu_ack, host_ack);
    end
    if (!ewe && ph) m_host_rdata = model_mem[ea];
    else if (!ewe) m_cpu_rdata = model_mem[ea];
    else if (!prot) model_mem[ea] = ed;
    else m_wp = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cpu_ack !== !ph || host_ack !== ph || cpu_rdata !== m_cpu_rdata || host_rdata !== m_host_rdata || wp_fault !== m_wp) begin
      failures++;
      $display("FAIL done_cycle: cack=%b hack=%b crd=%h hrd=%h wp=%b required cack=%b hack=%b crd=%h hrd=%h wp=%b",
               cpu_ack, host_ack, cpu_rdata, host_rdata, wp_fault, !ph, ph, m_cpu_rdata, m_host_rdata, m_wp);
    end
    cpu_req = 1'b0; host_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cpu_ack !== 1'b0 || host_ack !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL back_to_idle: cack=%b hack=%b busy=%b required 0 0 0", cpu_ack, host_ack, busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00 || cpu_ack !== 1'b0 || host_ack !== 1'b0 ||
        cpu_rdata !== 8'h00 || host_rdata !== 8'h00 || busy !== 1'b0 || wp_fault !== 1'b0 || grant_host !== 1'b1) begin
      failures++;
      $display("FAIL reset_values: rd=%b wr=%b addr=%h wd=%h cack=%b hack=%b crd=%h hrd=%h busy=%b wp=%b gh=%b required zeros and gh=1",
               mem_read, mem_write, mem_addr, mem_wdata, cpu_ack, host_ack, cpu_rdata, host_rdata, busy, wp_fault, grant_host);
    end
    @(negedge clk);
    reset = 1'b1;
    reset_model();
  endtask

  task automatic test_host_write_read();
    run_txn(2'b01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'hA5);
    run_txn(2'b01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    checks++;
    if (host_rdata !== 8'hA5 || cpu_rdata !== 8'h00) begin
      failures++;
      $display("FAIL host_readback: hrd=%h crd=%h required A5 00", host_rdata, cpu_rdata);
    end
  endtask

  task automatic test_cpu_gating();
    bit seen;
    run_txn(2'b01, 1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    seen = 1'b0;
    @(negedge clk);
    cpu_state = 2'b10; cpu_req = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (cpu_ack !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL cpu_gated: saw ack/busy=1 while cpu_state!=11, required none");
    end
    run_txn(2'b11, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_round_robin();
    int n, cyc, last_cyc;
    bit exp_host;
    apply_reset();
    n = 0; cyc = 0; last_cyc = -1; exp_host = 1'b0;
    @(negedge clk);
    cpu_state = 2'b11; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h31;
    while (n < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cpu_ack === 1'b1 || host_ack === 1'b1) begin
        checks++;
        if (host_ack !== exp_host || cpu_ack !== !exp_host) begin
          failures++;
          $display("FAIL rr_order: grant %0d cack=%b hack=%b required host=%b", n, cpu_ack, host_ack, exp_host);
        end
        checks++;
        if ((last_cyc < 0 && cyc != 3) || (last_cyc >= 0 && cyc - last_cyc != 4)) begin
          failures++;
          $display("FAIL rr_latency: grant %0d ack at cycle %0d (prev %0d) required 3 then every 4", n, cyc, last_cyc);
        end
        last_cyc = cyc;
        exp_host = !exp_host;
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL rr_timeout: saw %0d grants required 4", n);
    end
    cpu_req = 1'b0; host_req = 1'b0;
    repeat (2) @(posedge clk);
    apply_reset();
  endtask

  task automatic test_reset_mid_access();
    bit seen;
    @(negedge clk);
    cpu_req = 1'b0; host_req = 1'b1; host_we = 1'b1; host_addr = 8'h33; host_wdata = ~model_mem[8'h33];
    @(posedge clk); #1;
    checks++;
    if (mem_write !== 1'b1) begin
      failures++;
      $display("FAIL abort_setup: wr=%b required 1", mem_write);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00 || busy !== 1'b0 || grant_host !== 1'b1 ||
        cpu_ack !== 1'b0 || host_ack !== 1'b0 || cpu_rdata !== 8'h00 || host_rdata !== 8'h00 || wp_fault !== 1'b0) begin
      failures++;
      $display("FAIL abort_values: wr=%b rd=%b addr=%h busy=%b gh=%b cack=%b hack=%b crd=%h hrd=%h wp=%b required reset values",
               mem_write, mem_read, mem_addr, busy, grant_host, cpu_ack, host_ack, cpu_rdata, host_rdata, wp_fault);
    end
    host_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    reset_model();
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (cpu_ack !== 1'b0 || host_ack !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abort_no_ack: ack or busy seen after aborted access, required none");
    end
    run_txn(2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h33, 8'h00);
  endtask

  task automatic test_wrprot();
    run_txn(2'b11, 1'b1, 1'b1, 8'h05, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
`ifdef ARB_WRPROT_EN
    if (wp_fault !== 1'b1) begin
`else
    if (wp_fault !== 1'b0) begin
`endif
      failures++;
      $display("FAIL wp_flag: wp=%b required %b", wp_fault, m_wp);
    end
    run_txn(2'b11, 1'b1, 1'b1, 8'h45, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00);
    run_txn(2'b11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h06, 8'h66);
    run_txn(2'b11, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_random();
    apply_reset();
    repeat (80) begin
      run_txn(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)) & 8'hC7, 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)) & 8'hC7, 8'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; ram_clear = 1'b1;
    cpu_state = 2'b00; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'(i * 37 + 11);
    reset_model();
    repeat (2) @(negedge clk);
    ram_clear = 1'b0;
    reset = 1'b1;
    test_reset();
    test_host_write_read();
    test_cpu_gating();
    test_round_robin();
    test_reset_mid_access();
    test_wrprot();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
